// File: rtl/logicnets_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : logicnets_input_packer
// Purpose  : Quantises a stream of signed samples into 2-bit codes against
//            three thresholds and packs NUM_FEAT codes per output vector for
//            LogicNets layer 0. A sample flagged s_first while a vector is
//            partially filled restarts the vector.
// Options  : LNP_DROP_CNT_EN adds a saturating 16-bit drop_cnt output that
//            counts restarted (discarded) partial vectors.
// Revision : 1.0 - initial release
// ============================================================================
module logicnets_input_packer #(
  parameter int SAMPLE_W = 16,
  parameter int NUM_FEAT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_valid,
  input  logic                  s_first,
  output logic                  s_ready,
  input  logic [SAMPLE_W-1:0]   thr0,
  input  logic [SAMPLE_W-1:0]   thr1,
  input  logic [SAMPLE_W-1:0]   thr2,
  output logic [2*NUM_FEAT-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef LNP_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int IDX_W = (NUM_FEAT > 2) ? $clog2(NUM_FEAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_ready_en;

  logic             w_ge0;
  logic             w_ge1;
  logic             w_ge2;
  logic [1:0]       w_code;
  logic             w_xfer;
  logic             w_resync;
  logic [IDX_W-1:0] w_wr_idx;

  // Thermometer quantiser: number of thresholds the sample reaches.
  assign w_ge0  = $signed(s_data) >= $signed(thr0);
  assign w_ge1  = $signed(s_data) >= $signed(thr1);
  assign w_ge2  = $signed(s_data) >= $signed(thr2);
  assign w_code = {1'b0, w_ge0} + {1'b0, w_ge1} + {1'b0, w_ge2};

  // s_ready is held low until the first edge after reset; in HOLD a sample
  // may only enter together with the outgoing vector being accepted.
  assign s_ready  = r_ready_en & ((r_state == COLLECT) | m_ready);
  assign w_xfer   = s_valid & s_ready;
  assign w_resync = w_xfer & (r_state == COLLECT) & s_first & (r_idx != '0);

  // Slot written by the current transfer: slot 0 when starting a new vector.
  always_comb begin
    w_wr_idx = r_idx;
    if ((r_state == HOLD) || w_resync) begin
      w_wr_idx = '0;
    end
  end

  // Collect/hold state machine with the packed vector as its output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_idx      <= '0;
      r_ready_en <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_xfer) begin
        for (int i = 0; i < NUM_FEAT; i++) begin
          if (w_wr_idx == IDX_W'(i)) begin
            m_data[2*i +: 2] <= w_code;
          end
        end
      end
      case (r_state)
        COLLECT: begin
          if (w_xfer) begin
            if (w_resync) begin
              r_idx <= ONE_IDX;
            end else if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= HOLD;
              m_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + ONE_IDX;
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            r_state <= COLLECT;
            r_idx   <= w_xfer ? ONE_IDX : '0;
          end
        end
        default: begin
          r_state <= COLLECT;
          r_idx   <= '0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef LNP_DROP_CNT_EN
  // Saturating count of partial vectors discarded by an s_first restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (w_resync && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_logicnets_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_logicnets_input_packer
// Purpose  : Directed self-checking bench for logicnets_input_packer
//            (SAMPLE_W=16, NUM_FEAT=8, thresholds -100/0/100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_logicnets_input_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_first = 1'b0;
  logic        s_ready;
  logic [15:0] thr0 = 16'(-100);
  logic [15:0] thr1 = 16'd0;
  logic [15:0] thr2 = 16'd100;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
`ifdef LNP_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // One sample per code value: -200->0, -50->1, 0->2, 100->3.
  logic [15:0] code_smp [4];
  logic [15:0] cur_vec;
  logic [15:0] exp_vec;

  logicnets_input_packer #(.SAMPLE_W(16), .NUM_FEAT(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_first (s_first),
    .s_ready (s_ready),
    .thr0    (thr0),
    .thr1    (thr1),
    .thr2    (thr2),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready)
`ifdef LNP_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one sample for exactly one clock edge, then sample at edge+1.
  task automatic send(input logic [15:0] d, input logic f);
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  // Samples -200,-50,0,99,100,500,-100,-101 -> codes 0,1,2,2,3,3,1,0.
  task automatic send_ref_vector(input logic first0);
    send(16'(-200), first0);
    send(16'(-50), 1'b0);
    send(16'(0), 1'b0);
    send(16'(99), 1'b0);
    send(16'(100), 1'b0);
    send(16'(500), 1'b0);
    send(16'(-100), 1'b0);
    check("ref_mvalid_pre", 32'(m_valid), 32'd0);
    send(16'(-101), 1'b0);
  endtask

  initial begin
    code_smp[0] = 16'(-200);
    code_smp[1] = 16'(-50);
    code_smp[2] = 16'(0);
    code_smp[3] = 16'(100);

    // Reset state
    #3;
    check("rst_sready", 32'(s_ready), 32'd0);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mdata", 32'(m_data), 32'd0);
`ifdef LNP_DROP_CNT_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
    #9 rst = 1'b0;
    #1;
    check("rel_sready_noedge", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    check("rel_sready_edge", 32'(s_ready), 32'd1);

    // Reference vector, no stalls
    send_ref_vector(1'b0);
    check("ref_mvalid", 32'(m_valid), 32'd1);
    check("ref_mdata", 32'(m_data), 32'h1FA4);

    // Downstream stall with upstream pushing
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'(500);
    for (int c = 0; c < 5; c++) begin
      check("stall_sready", 32'(s_ready), 32'd0);
      check("stall_mvalid", 32'(m_valid), 32'd1);
      check("stall_mdata", 32'(m_data), 32'h1FA4);
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    #1;
    check("release_sready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    check("release_mvalid", 32'(m_valid), 32'd0);
    for (int k = 0; k < 7; k++) send(16'(-200), 1'b0);
    check("carry_mvalid", 32'(m_valid), 32'd1);
    check("carry_mdata", 32'(m_data), 32'h0003);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("drain_mvalid", 32'(m_valid), 32'd0);

    // Resync: 3 stale samples, then s_first sample plus 7 more
    for (int k = 0; k < 3; k++) send(16'(500), 1'b0);
    send(16'(-50), 1'b1);
    send(16'(-200), 1'b0);
    send(16'(0), 1'b0);
    send(16'(100), 1'b0);
    send(16'(-200), 1'b0);
    check("resync_no_early", 32'(m_valid), 32'd0);
    send(16'(-50), 1'b0);
    send(16'(50), 1'b0);
    send(16'(200), 1'b0);
    check("resync_mvalid", 32'(m_valid), 32'd1);
    check("resync_mdata", 32'(m_data), 32'hE4E1);
`ifdef LNP_DROP_CNT_EN
    check("resync_drop", 32'(drop_cnt), 32'd1);
`endif
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;

    // Asynchronous reset mid-collection
    for (int k = 0; k < 5; k++) send(16'(500), 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_mdata", 32'(m_data), 32'd0);
    check("arst_sready", 32'(s_ready), 32'd0);
    check("arst_mvalid", 32'(m_valid), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    send_ref_vector(1'b1);
    check("clean_mvalid", 32'(m_valid), 32'd1);
    check("clean_mdata", 32'(m_data), 32'h1FA4);
`ifdef LNP_DROP_CNT_EN
    check("clean_drop", 32'(drop_cnt), 32'd0);
`endif

    // Asynchronous reset while holding a vector
    #2 rst = 1'b1;
    #1;
    check("arst_hold_mvalid", 32'(m_valid), 32'd0);
    check("arst_hold_mdata", 32'(m_data), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back vectors, both sides always ready
    m_ready = 1'b1;
    cur_vec = '0;
    exp_vec = '0;
    for (int k = 0; k < 24; k++) begin
      int sel;
      sel = (k * 5 + k / 3) % 4;
      check("b2b_sready", 32'(s_ready), 32'd1);
      s_valid = 1'b1;
      s_data  = code_smp[sel];
      cur_vec[2*(k%8) +: 2] = 2'(sel);
      @(posedge clk);
      #1;
      if ((k % 8) == 7) begin
        exp_vec = cur_vec;
        check("b2b_mvalid_hi", 32'(m_valid), 32'd1);
        check("b2b_mdata", 32'(m_data), 32'(exp_vec));
      end else begin
        check("b2b_mvalid_lo", 32'(m_valid), 32'd0);
      end
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check("b2b_drained", 32'(m_valid), 32'd0);

`ifdef LNP_DROP_CNT_EN
    // Drop counter saturation: every s_first at index 1 is a drop
    send(16'(500), 1'b0);
    s_valid = 1'b1;
    s_first = 1'b1;
    s_data  = 16'(500);
    repeat (65534) @(posedge clk);
    #1;
    check("drop_fffe", 32'(drop_cnt), 32'h0000FFFE);
    repeat (3) @(posedge clk);
    #1;
    check("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
    s_valid = 1'b0;
    s_first = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
